// File: rtl/gpio_multi_if.sv
// gpio_multi_if: Wishbone slave bundle used by the GPIO controller
interface gpio_multi_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/gpio_multi.sv
// gpio_multi: Wishbone GPIO with direction, set/clear, synchronized inputs and edge interrupts
module gpio_multi #(
  parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
  parameter int          WIDTH       = 24,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  gpio_multi_if.slave      wb,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oeb,
  output logic             irq_o
);
  typedef logic [WIDTH-1:0] word_t;
  word_t out_q, oe_q, en_q, edge_q, stat_q, prev_q;
  word_t m, d, sync, evt, out_n, oe_n, en_n, edge_n, stat_n, rd;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [31:0] bm;
  logic [2:0] ra;
  logic acc, wr, unused;
  assign ra = wb.wbs_adr_i[4:2];
  assign acc = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]) & ~wb.wbs_ack_o;
  assign wr = acc & wb.wbs_we_i;
  assign bm = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}}, {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
  assign m = bm[WIDTH-1:0];
  assign d = wb.wbs_dat_i[WIDTH-1:0] & m;
  assign sync = sync_q[SYNC_STAGES-1];
  // IRQ_EDGE picks falling (1) or rising (0) per pin
  assign evt = (edge_q & ~sync & prev_q) | (~edge_q & sync & ~prev_q);
  assign gpio_out = out_q;
  assign gpio_oeb = ~oe_q;
  assign unused = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i, bm};
  always_comb begin
    out_n = (wr && ra == 3'd0) ? (out_q & ~m) | d :
            (wr && ra == 3'd3) ? out_q | d :
            (wr && ra == 3'd4) ? out_q & ~d : out_q;
    oe_n = (wr && ra == 3'd1) ? (oe_q & ~m) | d : oe_q;
    en_n = (wr && ra == 3'd5) ? (en_q & ~m) | d : en_q;
    edge_n = (wr && ra == 3'd6) ? (edge_q & ~m) | d : edge_q;
    stat_n = ((wr && ra == 3'd7) ? stat_q & ~d : stat_q) | evt;
    rd = (ra == 3'd0) ? out_q :
         (ra == 3'd1) ? oe_q :
         (ra == 3'd2) ? sync :
         (ra == 3'd5) ? en_q :
         (ra == 3'd6) ? edge_q :
         (ra == 3'd7) ? stat_q : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
      oe_q <= '0;
      en_q <= '0;
      edge_q <= '0;
      stat_q <= '0;
      prev_q <= '0;
      sync_q <= '0;
      irq_o <= 1'b0;
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      out_q <= out_n;
      oe_q <= oe_n;
      en_q <= en_n;
      edge_q <= edge_n;
      stat_q <= stat_n;
      prev_q <= sync;
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      // irq follows the post-update state so it tracks STAT/EN in the same cycle
      irq_o <= |(stat_n & en_n);
      wb.wbs_ack_o <= acc;
      if (acc && !wb.wbs_we_i) wb.wbs_dat_o <= 32'(rd);
    end
  end
endmodule

// File: tb/tb_gpio_multi.sv
// tb_gpio_multi: scoreboard bench for gpio_multi with a register-level reference model
module tb_gpio_multi;
  localparam int W = 24;
  localparam int S = 2;
  localparam logic [31:0] BASE = 32'h3001_0000;
  localparam logic [31:0] WM = 32'((64'd1 << W) - 1);
  typedef struct {
    bit          rd;
    logic [31:0] dat;
    logic [31:0] out;
    logic [31:0] oe;
    bit          irq;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out, gpio_oeb;
  logic irq;
  logic [31:0] m_out, m_oe, m_en, m_edge, m_stat;
  exp_t q[$];
  int errs = 0;
  int chks = 0;
  gpio_multi_if wb();
  gpio_multi #(.BASE_ADDR(BASE), .WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst), .wb(wb), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] lane_mask(logic [3:0] sel);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (sel[b]) r |= 32'hFF << (8 * b);
    return r & WM;
  endfunction
  function automatic logic [31:0] model_read(logic [2:0] r);
    case (r)
      3'd0: return m_out;
      3'd1: return m_oe;
      3'd2: return 32'(gpio_in);
      3'd5: return m_en;
      3'd6: return m_edge;
      3'd7: return m_stat;
      default: return '0;
    endcase
  endfunction
  task automatic model_write(logic [2:0] r, logic [31:0] dat, logic [3:0] sel);
    logic [31:0] lm = lane_mask(sel);
    logic [31:0] dm = dat & lm;
    case (r)
      3'd0: m_out = (m_out & ~lm) | dm;
      3'd1: m_oe = (m_oe & ~lm) | dm;
      3'd3: m_out = m_out | dm;
      3'd4: m_out = m_out & ~dm;
      3'd5: m_en = (m_en & ~lm) | dm;
      3'd6: m_edge = (m_edge & ~lm) | dm;
      3'd7: m_stat = m_stat & ~dm;
      default: ;
    endcase
  endtask
  task automatic model_reset();
    m_out = 0; m_oe = 0; m_en = 0; m_edge = 0; m_stat = 0;
  endtask
  task automatic set_pins(logic [W-1:0] v);
    logic [31:0] o = 32'(gpio_in);
    logic [31:0] n = 32'(v);
    m_stat |= ((~m_edge & ~o & n) | (m_edge & o & ~n)) & WM;
    gpio_in = v;
  endtask
  task automatic settle();
    repeat (S + 2) @(posedge clk);
    #1;
  endtask
  task automatic wb_xfer(bit we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel);
    exp_t e;
    int n;
    if (we) model_write(adr[4:2], dat, sel);
    e.rd = !we;
    e.dat = we ? 32'd0 : model_read(adr[4:2]);
    e.out = m_out;
    e.oe = m_oe;
    e.irq = |(m_stat & m_en);
    q.push_back(e);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
    for (n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o) break;
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    if (n == 20) begin
      chks++;
      errs++;
      $display("FAIL ack_timeout: no ack for adr %h", adr);
      void'(q.pop_back());
    end
  endtask
  task automatic monitor();
    bit pa = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb.wbs_ack_o) begin
        check("ack_width", 32'(pa), 0);
        if (q.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_ack: ack with no pending transfer at %0t", $time);
        end else begin
          e = q.pop_front();
          if (e.rd) check("rdata", wb.wbs_dat_o, e.dat);
          check("ack_gpio_out", 32'(gpio_out), e.out);
          check("ack_gpio_oeb", 32'(gpio_oeb), ~e.oe & WM);
          check("ack_irq", 32'(irq), 32'(e.irq));
        end
      end
      pa = wb.wbs_ack_o;
    end
  endtask
  task automatic stim();
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_adr_i = 0; wb.wbs_dat_i = 0; wb.wbs_sel_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_out", 32'(gpio_out), 0);
    check("rst_gpio_oeb", 32'(gpio_oeb), WM);
    check("rst_irq", 32'(irq), 0);
    check("rst_ack", 32'(wb.wbs_ack_o), 0);
    check("rst_dat", wb.wbs_dat_o, 0);
    rst = 0;
    settle();
    for (int r = 0; r < 8; r++) wb_xfer(0, BASE + 32'(r * 4), 0, 4'hF);
    wb_xfer(1, BASE + 32'h00, 32'h00A5A5, 4'b0001);
    wb_xfer(0, BASE + 32'h00, 0, 4'hF);
    wb_xfer(1, BASE + 32'h0C, 32'h000F00, 4'hF);
    wb_xfer(1, BASE + 32'h10, 32'h0000A0, 4'hF);
    check("out_set_clr", 32'(gpio_out), 32'h000F05);
    wb_xfer(1, BASE + 32'h04, 32'h0000FF, 4'hF);
    check("oeb_ff", 32'(gpio_oeb), 32'hFFFF00);
    wb_xfer(1, BASE + 32'h14, 32'h8, 4'hF);
    wb_xfer(1, BASE + 32'h18, 32'h0, 4'hF);
    set_pins(gpio_in | W'(8));
    for (int i = 1; i <= S + 1; i++) begin
      @(posedge clk);
      #1;
      check("irq_latency", 32'(irq), 32'(i == S + 1));
    end
    wb_xfer(0, BASE + 32'h1C, 0, 4'hF);
    wb_xfer(1, BASE + 32'h1C, 32'h8, 4'hF);
    wb_xfer(1, BASE + 32'h18, 32'h20, 4'hF);
    set_pins(gpio_in | W'(32'h20));
    settle();
    wb_xfer(0, BASE + 32'h1C, 0, 4'hF);
    set_pins(gpio_in & ~W'(32'h20));
    settle();
    wb_xfer(0, BASE + 32'h1C, 0, 4'hF);
    set_pins(gpio_in | W'(32'h20));
    settle();
    gpio_in[5] = 1'b0;
    repeat (S) @(posedge clk);
    #1;
    wb_xfer(1, BASE + 32'h1C, 32'h20, 4'hF);
    m_stat |= 32'h20;
    settle();
    wb_xfer(0, BASE + 32'h1C, 0, 4'hF);
    wb_xfer(1, BASE + 32'h1C, 32'h20, 4'hF);
    wb_xfer(0, BASE + 32'h1C, 0, 4'hF);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
    wb.wbs_adr_i = BASE + 32'h20; wb.wbs_dat_i = 32'hFFFFFF; wb.wbs_sel_i = 4'hF;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("outside_no_ack", 32'(wb.wbs_ack_o), 0);
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb_xfer(0, BASE + 32'h00, 0, 4'hF);
    for (int it = 0; it < 200; it++) begin
      int op = $urandom_range(0, 9);
      logic [2:0] r = 3'($urandom_range(0, 7));
      if (op < 5) wb_xfer(1, BASE + {27'd0, r, 2'b00}, $urandom, 4'($urandom));
      else if (op < 8) wb_xfer(0, BASE + {27'd0, r, 2'b00}, 0, 4'hF);
      else begin
        set_pins(W'($urandom));
        settle();
      end
    end
    settle();
    rst = 1;
    gpio_in = W'(32'h000012);
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
    wb.wbs_adr_i = BASE; wb.wbs_dat_i = 32'hFFFFFF; wb.wbs_sel_i = 4'hF;
    @(posedge clk);
    #1;
    check("rst_mid_ack", 32'(wb.wbs_ack_o), 0);
    check("rst_mid_out", 32'(gpio_out), 0);
    check("rst_mid_oeb", 32'(gpio_oeb), WM);
    check("rst_mid_irq", 32'(irq), 0);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    m_stat = 32'(gpio_in);
    settle();
    for (int r = 0; r < 8; r++) wb_xfer(0, BASE + 32'(r * 4), 0, 4'hF);
    repeat (2) @(posedge clk);
    check("queue_empty", 32'(q.size()), 0);
  endtask
  initial begin
    fork
      monitor();
      stim();
    join_any
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
